// File: rtl/collision_monitor.sv
// Frame-sequential collision monitor: scans one obstacle slot per clock against the
// plane's bounding box and runs the lives / grace / game-over life cycle.
module collision_monitor #(
    parameter int COORD_W      = 10,
    parameter int NUM_OBJ      = 4,
    parameter int HALF_W       = 6,
    parameter int PLANE_X      = 80,
    parameter int PLANE_HALF   = 8,
    parameter int LIVES        = 3,
    parameter int GRACE_FRAMES = 60,
    localparam int IDX_W       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        frame_tick,
    input  logic [COORD_W-1:0]          plane_y,
    input  logic [NUM_OBJ*COORD_W-1:0]  obj_x,
    input  logic [NUM_OBJ*COORD_W-1:0]  obj_y,
    input  logic [NUM_OBJ*HALF_W-1:0]   obj_hw,
    input  logic [NUM_OBJ*HALF_W-1:0]   obj_hh,
    input  logic [NUM_OBJ-1:0]          obj_valid,
    output logic                        crash_pulse,
    output logic [IDX_W-1:0]            hit_index,
    output logic [2:0]                  lives,
    output logic                        invulnerable,
    output logic                        game_over,
    output logic                        frame_done,
    output logic                        overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_GRACE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam int W2   = COORD_W + 2;
    localparam int GC_W = $clog2(GRACE_FRAMES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_OBJ - 1);
    localparam logic [2:0]       LIVES_INIT = 3'(LIVES);
    localparam logic [GC_W-1:0]  GRACE_INIT = GC_W'(GRACE_FRAMES);
    localparam logic [W2-1:0]    PX         = W2'(PLANE_X);
    localparam logic [W2-1:0]    PH         = W2'(PLANE_HALF);

    logic [2:0]                 r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [GC_W-1:0]            r_grace;
    logic [2:0]                 r_lives;
    logic                       r_crash;
    logic [IDX_W-1:0]           r_hit_idx;
    logic                       r_invuln;
    logic                       r_over;
    logic                       r_done;
    logic                       r_overrun;
    logic [COORD_W-1:0]         r_plane_y;
    logic [NUM_OBJ*COORD_W-1:0] r_obj_x;
    logic [NUM_OBJ*COORD_W-1:0] r_obj_y;
    logic [NUM_OBJ*HALF_W-1:0]  r_obj_hw;
    logic [NUM_OBJ*HALF_W-1:0]  r_obj_hh;
    logic [NUM_OBJ-1:0]         r_obj_valid;

    logic [COORD_W-1:0] w_ox;
    logic [COORD_W-1:0] w_oy;
    logic [HALF_W-1:0]  w_hw;
    logic [HALF_W-1:0]  w_hh;
    logic               w_valid;
    logic               w_x_hit;
    logic               w_y_hit;
    logic               w_hit;
    logic [2:0]         w_lives_dec;

    assign w_ox    = r_obj_x[r_idx*COORD_W +: COORD_W];
    assign w_oy    = r_obj_y[r_idx*COORD_W +: COORD_W];
    assign w_hw    = r_obj_hw[r_idx*HALF_W +: HALF_W];
    assign w_hh    = r_obj_hh[r_idx*HALF_W +: HALF_W];
    assign w_valid = r_obj_valid[r_idx];

    // Both sides of each comparison are sums only, so nothing wraps at screen edges.
    assign w_x_hit = (PX + PH + W2'(w_hw) >= W2'(w_ox)) &&
                     (W2'(w_ox) + W2'(w_hw) + PH >= PX);
    assign w_y_hit = (W2'(r_plane_y) + PH + W2'(w_hh) >= W2'(w_oy)) &&
                     (W2'(w_oy) + W2'(w_hh) + PH >= W2'(r_plane_y));
    assign w_hit   = w_valid && w_x_hit && w_y_hit;

    assign w_lives_dec = r_lives - 3'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_grace     <= '0;
            r_lives     <= LIVES_INIT;
            r_crash     <= 1'b0;
            r_hit_idx   <= '0;
            r_invuln    <= 1'b0;
            r_over      <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_plane_y   <= '0;
            r_obj_x     <= '0;
            r_obj_y     <= '0;
            r_obj_hw    <= '0;
            r_obj_hh    <= '0;
            r_obj_valid <= '0;
        end else begin
            r_crash <= 1'b0;
            r_done  <= 1'b0;
            // start wins over any tick or hit in the same cycle
            if (start) begin
                r_state   <= S_ARMED;
                r_lives   <= LIVES_INIT;
                r_overrun <= 1'b0;
                r_grace   <= '0;
                r_idx     <= '0;
                r_invuln  <= 1'b0;
                r_over    <= 1'b0;
            end else begin
                case (r_state)
                    S_ARMED: begin
                        if (frame_tick) begin
                            r_state     <= S_SCAN;
                            r_idx       <= '0;
                            r_plane_y   <= plane_y;
                            r_obj_x     <= obj_x;
                            r_obj_y     <= obj_y;
                            r_obj_hw    <= obj_hw;
                            r_obj_hh    <= obj_hh;
                            r_obj_valid <= obj_valid;
                        end
                    end
                    S_SCAN: begin
                        if (frame_tick) begin
                            r_overrun <= 1'b1;
                        end
                        if (w_hit) begin
                            r_crash   <= 1'b1;
                            r_hit_idx <= r_idx;
                            r_lives   <= w_lives_dec;
                            r_idx     <= '0;
                            if (w_lives_dec == 3'd0) begin
                                r_state <= S_OVER;
                                r_over  <= 1'b1;
                            end else begin
                                r_state  <= S_GRACE;
                                r_grace  <= GRACE_INIT;
                                r_invuln <= 1'b1;
                            end
                        end else if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= S_ARMED;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    S_GRACE: begin
                        if (frame_tick) begin
                            if (r_grace <= GC_W'(1)) begin
                                r_grace  <= '0;
                                r_state  <= S_ARMED;
                                r_invuln <= 1'b0;
                            end else begin
                                r_grace <= r_grace - GC_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign crash_pulse  = r_crash;
    assign hit_index    = r_hit_idx;
    assign lives        = r_lives;
    assign invulnerable = r_invuln;
    assign game_over    = r_over;
    assign frame_done   = r_done;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_collision_monitor.sv
// Directed bench for collision_monitor: hit timing, boundaries, grace, game over,
// screen-edge y handling, overrun and mid-scan reset.
module tb_collision_monitor;

    localparam int COORD_W = 10;
    localparam int NUM_OBJ = 4;
    localparam int HALF_W  = 6;
    localparam int IDX_W   = 2;

    logic                       clk;
    logic                       resetn;
    logic                       start;
    logic                       frame_tick;
    logic [COORD_W-1:0]         plane_y;
    logic [NUM_OBJ*COORD_W-1:0] obj_x;
    logic [NUM_OBJ*COORD_W-1:0] obj_y;
    logic [NUM_OBJ*HALF_W-1:0]  obj_hw;
    logic [NUM_OBJ*HALF_W-1:0]  obj_hh;
    logic [NUM_OBJ-1:0]         obj_valid;
    logic                       crash_pulse;
    logic [IDX_W-1:0]           hit_index;
    logic [2:0]                 lives;
    logic                       invulnerable;
    logic                       game_over;
    logic                       frame_done;
    logic                       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int crashes;
    int dones;
    logic inv_at_tick;

    collision_monitor #(
        .COORD_W(COORD_W), .NUM_OBJ(NUM_OBJ), .HALF_W(HALF_W), .PLANE_X(80),
        .PLANE_HALF(8), .LIVES(3), .GRACE_FRAMES(2)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .frame_tick(frame_tick),
        .plane_y(plane_y), .obj_x(obj_x), .obj_y(obj_y), .obj_hw(obj_hw),
        .obj_hh(obj_hh), .obj_valid(obj_valid), .crash_pulse(crash_pulse),
        .hit_index(hit_index), .lives(lives), .invulnerable(invulnerable),
        .game_over(game_over), .frame_done(frame_done), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic clear_objs();
        obj_x = '0; obj_y = '0; obj_hw = '0; obj_hh = '0; obj_valid = '0;
    endtask

    task automatic set_obj(input int i, input int x, input int y, input int hw, input int hh);
        obj_x[i*COORD_W +: COORD_W] = COORD_W'(x);
        obj_y[i*COORD_W +: COORD_W] = COORD_W'(y);
        obj_hw[i*HALF_W +: HALF_W]  = HALF_W'(hw);
        obj_hh[i*HALF_W +: HALF_W]  = HALF_W'(hh);
        obj_valid[i]                = 1'b1;
    endtask

    // Tick once, then watch six cycles for crash and frame_done pulses.
    task automatic scan_frame(output int n_crash, output int n_done, output logic inv);
        pulse_tick();
        inv     = invulnerable;
        n_crash = 0;
        n_done  = 0;
        repeat (6) begin
            cyc();
            n_crash += int'(crash_pulse);
            n_done  += int'(frame_done);
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; frame_tick = 1'b0; plane_y = '0;
        clear_objs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_lives", lives, 3);
        check("rst_crash", crash_pulse, 0);
        check("rst_hit_index", hit_index, 0);
        check("rst_invuln", invulnerable, 0);
        check("rst_game_over", game_over, 0);
        check("rst_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        resetn = 1'b1;
        cyc();

        // IDLE ignores frame_tick
        plane_y = 200;
        set_obj(0, 85, 200, 4, 4);
        scan_frame(crashes, dones, inv_at_tick);
        check("idle_no_crash", crashes, 0);
        check("idle_no_done", dones, 0);

        // basic hit: crash two cycles after the tick cycle
        pulse_start();
        pulse_tick();
        check("t1_crash_early", crash_pulse, 0);
        cyc();
        check("t1_crash", crash_pulse, 1);
        check("t1_hit_index", hit_index, 0);
        check("t1_lives", lives, 2);
        check("t1_invuln", invulnerable, 1);
        cyc();
        check("t1_crash_one_cycle", crash_pulse, 0);

        // inclusive x edge: 80+8+4 = 92 touches
        pulse_start();
        check("t2_restart_lives", lives, 3);
        check("t2_restart_invuln", invulnerable, 0);
        clear_objs();
        set_obj(0, 92, 200, 4, 4);
        pulse_tick();
        cyc();
        check("t2_edge_hit", crash_pulse, 1);
        check("t2_edge_lives", lives, 2);

        // one pixel further: no hit, frame_done NUM_OBJ+1 cycles after tick
        pulse_start();
        clear_objs();
        set_obj(0, 93, 200, 4, 4);
        pulse_tick();
        cyc(); cyc(); cyc();
        check("t2_done_early", frame_done, 0);
        cyc();
        check("t2_done", frame_done, 1);
        check("t2_no_crash", crash_pulse, 0);
        check("t2_lives_kept", lives, 3);
        cyc();
        check("t2_done_one_cycle", frame_done, 0);

        // slots 1 and 3 overlap: lowest wins, single pulse
        set_obj(1, 80, 200, 2, 2);
        set_obj(3, 80, 200, 2, 2);
        scan_frame(crashes, dones, inv_at_tick);
        check("t3_one_crash", crashes, 1);
        check("t3_no_done", dones, 0);
        check("t3_hit_index", hit_index, 1);
        check("t3_lives", lives, 2);
        check("t3_invuln", invulnerable, 1);
        scan_frame(crashes, dones, inv_at_tick);
        check("t3_grace1_crash", crashes, 0);
        check("t3_grace1_done", dones, 0);
        check("t3_grace1_invuln", inv_at_tick, 1);
        scan_frame(crashes, dones, inv_at_tick);
        check("t3_grace2_crash", crashes, 0);
        check("t3_grace2_done", dones, 0);
        check("t3_grace2_invuln", inv_at_tick, 0);
        scan_frame(crashes, dones, inv_at_tick);
        check("t3_rescan_crash", crashes, 1);
        check("t3_rescan_lives", lives, 1);

        // three fatal hits end the game
        pulse_start();
        check("t4_start_lives", lives, 3);
        for (int h = 1; h <= 3; h++) begin
            scan_frame(crashes, dones, inv_at_tick);
            check("t4_hit_crash", crashes, 1);
            check("t4_hit_lives", lives, 3 - h);
            if (h < 3) begin
                scan_frame(crashes, dones, inv_at_tick);
                scan_frame(crashes, dones, inv_at_tick);
                check("t4_grace_exit", invulnerable, 0);
            end
        end
        check("t4_game_over", game_over, 1);
        check("t4_over_invuln", invulnerable, 0);
        scan_frame(crashes, dones, inv_at_tick);
        check("t4_over_no_crash", crashes, 0);
        check("t4_over_no_done", dones, 0);
        check("t4_over_held", game_over, 1);
        check("t4_over_lives", lives, 0);
        pulse_start();
        check("t4_restart_over", game_over, 0);
        check("t4_restart_lives", lives, 3);

        // y near 0 against object near 1023: no wrap, and overrun on a mid-scan tick
        clear_objs();
        plane_y = 2;
        set_obj(0, 80, 1020, 4, 4);
        pulse_tick();
        cyc();
        check("t5_crash_k0", crash_pulse, 0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("t5_overrun", overrun, 1);
        check("t5_crash_k1", crash_pulse, 0);
        cyc(); cyc();
        check("t5_done", frame_done, 1);
        check("t5_no_crash", crash_pulse, 0);
        check("t5_lives", lives, 3);
        scan_frame(crashes, dones, inv_at_tick);
        check("t5_frame2_done", dones, 1);
        check("t5_frame2_crash", crashes, 0);
        check("t5_overrun_held", overrun, 1);
        pulse_start();
        check("t5_overrun_clear", overrun, 0);

        // near the top edge the sums stay in range and the hit is seen
        clear_objs();
        plane_y = 1015;
        set_obj(2, 80, 1023, 4, 4);
        scan_frame(crashes, dones, inv_at_tick);
        check("t5_top_crash", crashes, 1);
        check("t5_top_index", hit_index, 2);
        check("t5_top_lives", lives, 2);
        scan_frame(crashes, dones, inv_at_tick);
        scan_frame(crashes, dones, inv_at_tick);
        check("t6_armed_again", invulnerable, 0);

        // reset during SCAN cycle 1 with a slot-1 hit pending
        clear_objs();
        plane_y = 200;
        set_obj(1, 80, 200, 2, 2);
        frame_tick = 1'b1;
        cyc();
        cyc();
        frame_tick = 1'b0;
        check("t6_overrun_pre", overrun, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_rst_lives", lives, 3);
        check("t6_rst_hit_index", hit_index, 0);
        check("t6_rst_overrun", overrun, 0);
        check("t6_rst_crash", crash_pulse, 0);
        check("t6_rst_invuln", invulnerable, 0);
        check("t6_rst_over", game_over, 0);
        cyc();
        resetn = 1'b1;
        crashes = 0;
        repeat (5) begin
            cyc();
            crashes += int'(crash_pulse);
        end
        check("t6_no_crash_after", crashes, 0);
        check("t6_no_done_after", frame_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/collision_monitor.md
Name: collision_monitor

Overview:
- Parametrised, sequential successor to the combinational crash check.
- Checks the plane's bounding box against NUM_OBJ obstacles (mountains, lava, …) once per video frame, one object per clock.
- Runs the game life cycle: lives counter, post-hit invulnerability grace window, sticky game-over state.
- Sits between the object/position generators and the VGA draw controller and score logic.

Parameters:
- COORD_W, 10, coordinate width in bits.
- NUM_OBJ, 4, number of obstacle slots (1..16).
- HALF_W, 6, width of the per-object half-size fields.
- PLANE_X, 80, fixed plane centre x.
- PLANE_HALF, 8, plane half-size in x and y.
- LIVES, 3, lives loaded on start (1..7).
- GRACE_FRAMES, 60, frames of invulnerability after a non-fatal hit (≥1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: begin or restart a game.
- frame_tick  in  1  single-cycle pulse once per frame.
- plane_y  in  COORD_W  plane centre y.
- obj_x  in  NUM_OBJ*COORD_W  object centre x; slot i at [i*COORD_W +: COORD_W].
- obj_y  in  NUM_OBJ*COORD_W  object centre y, same packing.
- obj_hw  in  NUM_OBJ*HALF_W  object half-width.
- obj_hh  in  NUM_OBJ*HALF_W  object half-height.
- obj_valid  in  NUM_OBJ  slot enable; invalid slots never hit.
- crash_pulse  out  1  one-cycle pulse per registered hit.
- hit_index  out  clog2(NUM_OBJ) (min 1)  slot of the last hit.
- lives  out  3  remaining lives.
- invulnerable  out  1  high while in GRACE.
- game_over  out  1  high while in OVER.
- frame_done  out  1  one-cycle pulse: scan finished with no hit.
- overrun  out  1  sticky flag: frame_tick arrived during SCAN.

Behaviour:
- Reset (async, resetn=0): state=IDLE; crash_pulse=0, hit_index=0, lives=LIVES, invulnerable=0, game_over=0, frame_done=0, overrun=0; scan index and grace counter cleared. Reset mid-scan abandons the scan with no pulse.
- States: IDLE, ARMED, SCAN, GRACE, OVER.
- IDLE: start -> ARMED, lives=LIVES, overrun=0. frame_tick is ignored.
- ARMED: frame_tick -> SCAN. On that edge, snapshot plane_y and all obj_* / obj_valid. The scan uses only the snapshots.
- SCAN: lasts NUM_OBJ cycles. In SCAN cycle k (k=0 is the cycle after the accepting tick), slot k is compared.
  - Hit (first hit is lowest index; scan aborts): next cycle crash_pulse=1, hit_index=k, lives=lives-1.
  - If the new lives value is 0 -> OVER. Otherwise -> GRACE with grace counter=GRACE_FRAMES.
  - No hit in all slots: frame_done pulses the cycle after slot NUM_OBJ-1; state -> ARMED.
  - frame_tick during SCAN: ignored, and overrun is set.
- Hit test for slot k: requires obj_valid[k] and overlap in both axes. Boundaries are inclusive (touching edges count as a hit).
  - x axis: (PLANE_X+PLANE_HALF+hw ≥ ox) and (ox+hw+PLANE_HALF ≥ PLANE_X).
  - y axis: the same form with plane_y and hh.
  - All sums are computed in COORD_W+2 bits with zero-extension. No subtraction is used, so no wrap-around at the screen edges: y=0 and y=2^COORD_W−1 are handled correctly.
- GRACE: invulnerable=1. Each frame_tick decrements the counter; no scan runs. When the counter reaches 0 on a tick -> ARMED (next tick scans).
- OVER: game_over=1 and held. frame_tick is ignored. start -> ARMED with lives=LIVES, game_over=0, invulnerable=0, overrun=0.
- start in ARMED/SCAN/GRACE: restarts. -> ARMED, lives=LIVES, any scan is aborted with no pulse, grace is cleared. start takes priority over a simultaneous frame_tick or hit.
- Output timing: all outputs are registered. crash_pulse and frame_done are high exactly one cycle.

Test Plan:
- Reset then start; frame_tick with plane_y=200, obj0 at (85,200) hw=hh=4 valid, others invalid -> crash_pulse 2 cycles after tick, hit_index=0, lives=2, invulnerable=1.
- Boundary: obj0 x = 80+8+4 = 92, y equal to plane_y -> hit. x=93 -> no hit; frame_done pulses NUM_OBJ+1 cycles after tick.
- Slots 1 and 3 both overlapping -> single crash_pulse, hit_index=1. With GRACE_FRAMES=2: the next 2 ticks produce no scan, invulnerable drops on the 2nd tick, and the 3rd tick scans.
- Three fatal hits with LIVES=3 -> lives=0 and game_over=1; further ticks give no pulses; start -> game_over=0, lives=3.
- plane_y=2 with obj_y=1020, hh=4, overlapping in x -> no hit (no underflow wrap). frame_tick mid-SCAN -> overrun=1, held until start.
- Assert resetn low during SCAN cycle 1 -> outputs at reset values immediately, no crash_pulse after release.
